uart_receiver: RTL



---
 rtl/uart_receiver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART 16750 serial receive stage: majority-filtered 16x oversampling of SIN,
// frame recovery (5-8 data bits, optional parity, stop) and status commit.
module uart_receiver (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       RXCLEAR,
  input  logic [1:0] WLS,
  input  logic       STB,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  input  logic       SIN,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic [7:0] DOUT,
  output logic       RXFINISHED
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, MWAIT} state_t;

  state_t     state;
  logic       sync0, sync1, hist0, hist1, rx;
  logic [3:0] tcnt;
  logic [2:0] bcnt;
  logic [7:0] shreg;
  logic       par_bit;
  logic [2:0] last_bit;
  logic [7:0] data_mask;
  logic [7:0] data_w;
  logic       exp_par;

  // Only the first stop bit is ever checked, so the stop-bit count is irrelevant here.
  logic unused_stb;
  assign unused_stb = STB;

  // SIN resynchronisation followed by a 3-sample majority filter clocked by the baud tick.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync0 <= 1'b1;
      sync1 <= 1'b1;
      hist0 <= 1'b1;
      hist1 <= 1'b1;
      rx    <= 1'b1;
    end else begin
      sync0 <= SIN;
      sync1 <= sync0;
      if (RXCLK) begin
        hist0 <= sync1;
        hist1 <= hist0;
        rx    <= (sync1 & hist0) | (sync1 & hist1) | (hist0 & hist1);
      end
    end
  end

  assign last_bit = {1'b0, WLS} + 3'd4;

  always_comb begin
    data_mask = 8'hFF;
    case (WLS)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  end

  assign data_w  = shreg & data_mask;
  assign exp_par = SP ? ~EPS : (EPS ? ^data_w : ~^data_w);

  // Frame FSM; the status outputs only change when a stop bit is committed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      tcnt       <= 4'd0;
      bcnt       <= 3'd0;
      shreg      <= 8'd0;
      par_bit    <= 1'b0;
      DOUT       <= 8'd0;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
    end else begin
      RXFINISHED <= 1'b0;
      if (RXCLEAR) begin
        state <= IDLE;
        tcnt  <= 4'd0;
        bcnt  <= 3'd0;
        shreg <= 8'd0;
      end else if (RXCLK) begin
        case (state)
          IDLE: begin
            tcnt <= 4'd0;
            if (!rx) state <= START;
          end
          START: begin
            if (tcnt == 4'd7) begin
              tcnt <= 4'd0;
              if (rx) begin
                state <= IDLE;
              end else begin
                state <= DATA;
                bcnt  <= 3'd0;
                shreg <= 8'd0;
              end
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          DATA: begin
            if (tcnt == 4'd15) begin
              shreg[bcnt] <= rx;
              tcnt        <= 4'd0;
              bcnt        <= bcnt + 3'd1;
              if (bcnt == last_bit) state <= PEN ? PAR : STOP;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          PAR: begin
            if (tcnt == 4'd15) begin
              par_bit <= rx;
              tcnt    <= 4'd0;
              state   <= STOP;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          STOP: begin
            if (tcnt == 4'd15) begin
              tcnt       <= 4'd0;
              DOUT       <= data_w;
              FE         <= ~rx;
              PE         <= PEN & (par_bit != exp_par);
              BI         <= (data_w == 8'd0) & (~PEN | ~par_bit) & ~rx;
              RXFINISHED <= 1'b1;
              state      <= rx ? IDLE : MWAIT;
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
          MWAIT: begin
            if (rx) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
